// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction fetches and data loads/stores onto one variable-latency single-port RAM.
// Optional MEM_TIMEOUT_EN: abort a stalled serve after TIMEOUT cycles with a zero-data hit and sticky err.

module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              ihit,
   output logic [DATA_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic              dhit,
   output logic [DATA_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   input  logic [DATA_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   output logic              err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DSERV = 2'd1,
      ISERV = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [1:0] RAM_ACCESS = 2'd2;

   state_t            state_r, state_s;
   logic              dside_r, dside_s;
   logic              wr_r, wr_s;
   logic [ADDR_W-1:0] addr_r, addr_s;
   logic [DATA_W-1:0] store_r, store_s;
   logic [DATA_W-1:0] iload_r, iload_s;
   logic [DATA_W-1:0] dload_r, dload_s;
   logic              ihit_r, ihit_s;
   logic              dhit_r, dhit_s;
   logic              ren_r, ren_s;
   logic              wen_r, wen_s;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic              err_r, err_s;
`else
   // Keeps TIMEOUT referenced when the watchdog is compiled out.
   localparam int timeout_unused = TIMEOUT;
`endif

   // Next-state, transaction latch and registered-output next values.
   always_comb begin
      state_s = state_r;
      dside_s = dside_r;
      wr_s    = wr_r;
      addr_s  = addr_r;
      store_s = store_r;
      iload_s = iload_r;
      dload_s = dload_r;
`ifdef MEM_TIMEOUT_EN
      cnt_s   = cnt_r;
      err_s   = err_r;
`endif
      case (state_r)
         IDLE: begin
`ifdef MEM_TIMEOUT_EN
            cnt_s = {CNT_W{1'b0}};
`endif
            if (dWEN || dREN) begin
               state_s = DSERV;
               dside_s = 1'b1;
               wr_s    = dWEN;
               addr_s  = daddr;
               store_s = dstore;
            end else if (iREN) begin
               state_s = ISERV;
               dside_s = 1'b0;
               wr_s    = 1'b0;
               addr_s  = iaddr;
            end else begin
               state_s = IDLE;
            end
         end
         DSERV, ISERV: begin
            // FREE, BUSY and ERROR all hold; ERROR retries with strobes still up.
            if (ramstate == RAM_ACCESS) begin
               state_s = RESP;
               if (state_r == ISERV) begin
                  iload_s = ramload;
               end else if (!wr_r) begin
                  dload_s = ramload;
               end else begin
                  dload_s = dload_r;
               end
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
               state_s = RESP;
               err_s   = 1'b1;
               if (state_r == ISERV) begin
                  iload_s = {DATA_W{1'b0}};
               end else begin
                  dload_s = {DATA_W{1'b0}};
               end
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
`else
            else begin
               state_s = state_r;
            end
`endif
         end
         RESP: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      ren_s  = (state_s == ISERV) || ((state_s == DSERV) && !wr_s);
      wen_s  = (state_s == DSERV) && wr_s;
      ihit_s = (state_s == RESP) && !dside_s;
      dhit_s = (state_s == RESP) && dside_s;
   end

   // State, latched transaction and registered outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= IDLE;
         dside_r <= 1'b0;
         wr_r    <= 1'b0;
         addr_r  <= {ADDR_W{1'b0}};
         store_r <= {DATA_W{1'b0}};
         iload_r <= {DATA_W{1'b0}};
         dload_r <= {DATA_W{1'b0}};
         ihit_r  <= 1'b0;
         dhit_r  <= 1'b0;
         ren_r   <= 1'b0;
         wen_r   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         cnt_r   <= {CNT_W{1'b0}};
         err_r   <= 1'b0;
`endif
      end else begin
         state_r <= state_s;
         dside_r <= dside_s;
         wr_r    <= wr_s;
         addr_r  <= addr_s;
         store_r <= store_s;
         iload_r <= iload_s;
         dload_r <= dload_s;
         ihit_r  <= ihit_s;
         dhit_r  <= dhit_s;
         ren_r   <= ren_s;
         wen_r   <= wen_s;
`ifdef MEM_TIMEOUT_EN
         cnt_r   <= cnt_s;
         err_r   <= err_s;
`endif
      end
   end

   assign ihit     = ihit_r;
   assign dhit     = dhit_r;
   assign iload    = iload_r;
   assign dload    = dload_r;
   assign ramREN   = ren_r;
   assign ramWEN   = wen_r;
   assign ramaddr  = addr_r;
   assign ramstore = store_r;
`ifdef MEM_TIMEOUT_EN
   assign err      = err_r;
`else
   assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (word memory, expected load registers, expected cycle-by-cycle strobes).

module tb_mem_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic [1:0]  ramstate;
   logic        ihit, dhit, ramREN, ramWEN, err;
   logic [31:0] iload, dload, ramaddr, ramstore;

   int          n_checks = 0;
   int          n_fail   = 0;

   logic [31:0] mem [logic [31:0]];
   logic [31:0] exp_iload = 32'd0;
   logic [31:0] exp_dload = 32'd0;
   logic        exp_err   = 1'b0;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dhit(dhit), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .err(err)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (!mem.exists(a)) mem[a] = $urandom;
      return mem[a];
   endfunction

   task automatic idle_inputs();
      iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      ramstate = 2'd0;
      ramload  = $urandom;
   endtask

   // kind: 0 fetch, 1 data read, 2 data write. delay non-ACCESS cycles precede ACCESS.
   task automatic do_txn(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                         input int delay, input int wait_kind);
      logic [31:0] rd_val;
      logic [3:0]  got4;
      logic [3:0]  exp4;
      int          pick;
      rd_val = 32'd0;
      iREN = (kind == 0); dREN = (kind == 1); dWEN = (kind == 2);
      iaddr = addr; daddr = addr; dstore = wdata;
      ramstate = 2'd0;
      tick();
      for (int w = 0; w <= delay; w++) begin
         if (w < delay) begin
            pick = (wait_kind == 0) ? int'($urandom_range(0, 2)) : wait_kind;
            ramstate = (pick == 2 || pick == 3) ? 2'd3 : 2'(pick);
            ramload  = $urandom;
         end else begin
            ramstate = 2'd2;
            if (kind != 2) begin
               rd_val  = mem_read(addr);
               ramload = rd_val;
            end else begin
               ramload = $urandom;
            end
         end
         if (w > 0) begin
            iaddr = $urandom; daddr = $urandom; dstore = $urandom;
         end
         got4 = {ramREN, ramWEN, ihit, dhit};
         exp4 = {(kind != 2), (kind == 2), 1'b0, 1'b0};
         n_checks++;
         if (got4 !== exp4) begin
            n_fail++;
            $display("FAIL serv_strobes kind=%0d w=%0d: got %b want %b", kind, w, got4, exp4);
         end
         n_checks++;
         if (ramaddr !== addr) begin
            n_fail++;
            $display("FAIL serv_addr kind=%0d w=%0d: got %h want %h", kind, w, ramaddr, addr);
         end
         if (kind == 2) begin
            n_checks++;
            if (ramstore !== wdata) begin
               n_fail++;
               $display("FAIL serv_store w=%0d: got %h want %h", w, ramstore, wdata);
            end
         end
         tick();
      end
      if (kind == 2) mem[addr] = wdata;
      else if (kind == 1) exp_dload = rd_val;
      else exp_iload = rd_val;
      got4 = {ramREN, ramWEN, ihit, dhit};
      exp4 = {1'b0, 1'b0, (kind == 0), (kind != 0)};
      n_checks++;
      if (got4 !== exp4) begin
         n_fail++;
         $display("FAIL resp_hits kind=%0d: got %b want %b", kind, got4, exp4);
      end
      n_checks++;
      if (iload !== exp_iload || dload !== exp_dload) begin
         n_fail++;
         $display("FAIL resp_loads kind=%0d: got i=%h d=%h want i=%h d=%h",
                  kind, iload, dload, exp_iload, exp_dload);
      end
      n_checks++;
      if (err !== exp_err) begin
         n_fail++;
         $display("FAIL resp_err: got %b want %b", err, exp_err);
      end
      idle_inputs();
      tick();
      n_checks++;
      if ({ramREN, ramWEN, ihit, dhit} !== 4'b0000) begin
         n_fail++;
         $display("FAIL post_idle: got %b want 0000", {ramREN, ramWEN, ihit, dhit});
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      idle_inputs();
      iaddr = 32'd0; daddr = 32'd0; dstore = 32'd0;
      tick();
      tick();
      n_checks++;
      if ({ihit, dhit, ramREN, ramWEN, err} !== 5'b00000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 00000", {ihit, dhit, ramREN, ramWEN, err});
      end
      n_checks++;
      if ({iload, dload, ramaddr, ramstore} !== 128'd0) begin
         n_fail++;
         $display("FAIL reset_data: got %h %h %h %h want 0", iload, dload, ramaddr, ramstore);
      end
      RST = 1'b0;
      tick();
   endtask

   task automatic test_directed();
      mem[32'h40] = 32'h3C01_0004;
      do_txn(0, 32'h0000_0040, 32'd0, 0, 1);
      do_txn(2, 32'h0000_0080, 32'hDEAD_BEEF, 4, 1);
      do_txn(1, 32'h0000_0080, 32'd0, 3, 3);
   endtask

   task automatic test_simultaneous();
      logic [31:0] dv, iv;
      iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
      iaddr = 32'h200; daddr = 32'h100; ramstate = 2'd0;
      tick();
      n_checks++;
      if ({ramREN, ramWEN} !== 2'b10 || ramaddr !== 32'h100) begin
         n_fail++;
         $display("FAIL simul_dfirst: got ren/wen=%b addr=%h want 10 addr=00000100", {ramREN, ramWEN}, ramaddr);
      end
      dv = mem_read(32'h100);
      ramstate = 2'd2; ramload = dv;
      tick();
      exp_dload = dv;
      n_checks++;
      if ({ihit, dhit} !== 2'b01 || dload !== exp_dload) begin
         n_fail++;
         $display("FAIL simul_dhit: got hits=%b dload=%h want 01 %h", {ihit, dhit}, dload, exp_dload);
      end
      dREN = 1'b0; ramstate = 2'd0; ramload = $urandom;
      tick();
      n_checks++;
      if ({ramREN, ramWEN, ihit, dhit} !== 4'b0000) begin
         n_fail++;
         $display("FAIL simul_gap: got %b want 0000", {ramREN, ramWEN, ihit, dhit});
      end
      tick();
      n_checks++;
      if (ramREN !== 1'b1 || ramaddr !== 32'h200) begin
         n_fail++;
         $display("FAIL simul_iserv: got ren=%b addr=%h want 1 00000200", ramREN, ramaddr);
      end
      iv = mem_read(32'h200);
      ramstate = 2'd2; ramload = iv;
      tick();
      exp_iload = iv;
      n_checks++;
      if ({ihit, dhit} !== 2'b10 || iload !== exp_iload) begin
         n_fail++;
         $display("FAIL simul_ihit: got hits=%b iload=%h want 10 %h", {ihit, dhit}, iload, exp_iload);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_mid();
      iREN = 1'b1; iaddr = 32'h44; ramstate = 2'd1;
      tick();
      n_checks++;
      if (ramREN !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_serv: got ren=%b want 1", ramREN);
      end
      RST = 1'b1;
      tick();
      RST = 1'b0;
      idle_inputs();
      exp_iload = 32'd0; exp_dload = 32'd0; exp_err = 1'b0;
      n_checks++;
      if ({ramREN, ramWEN, ihit, dhit} !== 4'b0000 || iload !== 32'd0 || dload !== 32'd0) begin
         n_fail++;
         $display("FAIL rstmid_clear: got %b iload=%h dload=%h want 0000 0 0",
                  {ramREN, ramWEN, ihit, dhit}, iload, dload);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++;
         if ({ramREN, ramWEN, ihit, dhit} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstmid_nohit k=%0d: got %b want 0000", k, {ramREN, ramWEN, ihit, dhit});
         end
      end
   endtask

   task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
      dREN = 1'b1; daddr = 32'h300; ramstate = 2'd1;
      tick();
      for (int w = 0; w < 8; w++) begin
         n_checks++;
         if (ramREN !== 1'b1 || dhit !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_wait w=%0d: got ren=%b dhit=%b want 1 0", w, ramREN, dhit);
         end
         tick();
      end
      exp_dload = 32'd0; exp_err = 1'b1;
      n_checks++;
      if (dhit !== 1'b1 || dload !== 32'd0 || err !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_hit: got dhit=%b dload=%h err=%b want 1 0 1", dhit, dload, err);
      end
      idle_inputs();
      tick();
      do_txn(0, 32'h8, 32'd0, 2, 0);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      exp_err = 1'b0; exp_iload = 32'd0; exp_dload = 32'd0;
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_clear: got err=%b want 0", err);
      end
`endif
   endtask

   task automatic test_random();
      int          kind;
      logic [31:0] a;
      for (int t = 0; t < 60; t++) begin
         kind = int'($urandom_range(0, 2));
         a    = 32'($urandom_range(0, 7)) << 2;
         do_txn(kind, a, $urandom, int'($urandom_range(0, 5)), 0);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_simultaneous();
      test_reset_mid();
      test_timeout();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Responder end of the datapath memory request interface.
- Accepts instruction-fetch requests and data load/store requests, which the datapath raises from the decoded dmemREN/dmemWEN controls.
- Serialises them onto one single-port RAM with variable latency, and returns one-cycle ihit/dhit pulses with registered load data.
- Sits between the datapath/cache side and the RAM model.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data word width
TIMEOUT, 64, max cycles in a serve state before abort (only with MEM_TIMEOUT_EN)

Ports:
CLK  in  1  system clock; all state changes on rising edge
RST  in  1  synchronous active-high reset
iREN  in  1  instruction read request, level, held until ihit
iaddr  in  ADDR_W  instruction address
ihit  out  1  one-cycle pulse: iload valid
iload  out  DATA_W  registered instruction word
dREN  in  1  data read request, level, held until dhit
dWEN  in  1  data write request, level, held until dhit
daddr  in  ADDR_W  data address
dstore  in  DATA_W  store data
dhit  out  1  one-cycle pulse: load data valid or store complete
dload  out  DATA_W  registered load data
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
ramload  in  DATA_W  RAM read data, valid when ramstate==ACCESS
ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
err  out  1  sticky timeout flag (tied 0 without MEM_TIMEOUT_EN)

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on RST.
- Reset values: state=IDLE; ihit, dhit, ramREN, ramWEN, err = 0; iload, dload, ramaddr, ramstore, latched regs = 0.
- States: IDLE, DSERV, ISERV, RESP.
- IDLE:
  - If dWEN|dREN: latch daddr, dstore and op, then go to DSERV. Write wins if dWEN and dREN are both high.
  - Else if iREN: latch iaddr, then go to ISERV.
  - Else stay in IDLE.
  - Data always has priority over instruction.
- DSERV/ISERV:
  - RAM outputs are driven from the latched regs only, never directly from live inputs.
  - ramREN = latched read or ISERV; ramWEN = latched write; the two are never both 1.
  - ramstate FREE or BUSY: hold.
  - ramstate ERROR: hold and keep the strobes asserted (retry).
  - ramstate ACCESS: capture ramload into dload (DSERV read) or iload (ISERV), then go to RESP. On writes, dload is unchanged.
- RESP:
  - Exactly one of dhit/ihit is high for this single cycle, matching the served side.
  - RAM strobes are 0.
  - Next state is IDLE unconditionally. This gives the requester one cycle to drop or change its request before re-sampling.
- Latency: the hit is asserted 2 cycles after the first ACCESS-eligible cycle. Minimum request-to-hit is 3 cycles (IDLE sample, SERV with ACCESS, RESP).
- If a request is withdrawn or changed during SERV, the latched transaction still completes and its hit is still pulsed. The requester must ignore it.
- Simultaneous i and d requests: data is served first. The instruction is served on the next IDLE visit if still pending. Instruction starvation under continuous data traffic is permitted.
- iload/dload hold their value until the next capture.
- RST mid-transaction: at the next edge the FSM returns to IDLE with the strobes low. The transaction is discarded, no hit is generated, and the load regs clear.
- The module has no combinational path from any input to any output.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- When defined:
  - A cycle counter clears on SERV entry and increments each SERV cycle.
  - When it reaches TIMEOUT without ACCESS, the FSM goes to RESP and pulses the corresponding hit with load data 0.
  - err is set and stays 1 until RST.
- When undefined: no counter, SERV waits indefinitely, and err is constant 0.

Test Plan:
- Reset, then iREN=1, iaddr=0x0000_0040, ramstate=ACCESS with ramload=0x3C01_0004 at first SERV cycle -> ramREN=1, ramaddr=0x40 in ISERV; ihit pulses 1 cycle with iload=0x3C01_0004; total 3 cycles.
- dWEN=1, daddr=0x80, dstore=0xDEAD_BEEF, ramstate BUSY for 4 cycles then ACCESS -> ramWEN=1 with ramaddr=0x80 and ramstore=0xDEAD_BEEF held for 5 cycles; dhit in the following cycle; ramREN stays 0 throughout.
- iREN=1 and dREN=1 together in the same cycle, daddr=0x100 -> the data read is served first with dhit; the instruction is then served and ihit follows with no overlap of ramREN addresses.
- In ISERV with ramstate=BUSY, assert RST for 1 cycle -> next cycle state IDLE, ramREN=0, iload=0, no ihit.
- ramstate=ERROR for 3 cycles then ACCESS -> strobes are held through ERROR and the hit arrives normally. With MEM_TIMEOUT_EN and TIMEOUT=8, ramstate stuck BUSY -> hit after 8 SERV cycles with dload=0, and err=1 sticky until RST.
